// File: rtl/arb_rr8_enc.sv
// 8-way round-robin arbiter with registered one-hot grant and binary index; optional hold timeout (ARB_TIMEOUT_EN).
// Latency: grant visible one edge after request; a one-cycle GAP always separates grants.
// Backpressure: holder keeps the grant while its req stays high (bounded by HOLD_MAX when ARB_TIMEOUT_EN).
module arb_rr8_enc #(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    generate
        if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
            $error("HOLD_MAX must be within 2..255");
        end
    endgenerate

    state_t     state;
    logic [2:0] ptr;
    logic [2:0] pick_id;
    logic       pick_vld;
    logic [2:0] idx;
    logic       hold_req;
    logic       force_rel;

    assign hold_req = req[gnt_id];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic       timeout_q;

    assign force_rel = (hold_cnt == 8'(HOLD_MAX));
    assign timeout   = timeout_q;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    // First requester found walking upward from ptr, wrapping 7 -> 0.
    always_comb begin
        pick_id  = 3'd0;
        pick_vld = 1'b0;
        idx      = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!pick_vld && req[idx]) begin
                pick_vld = 1'b1;
                pick_id  = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            gnt       <= 8'd0;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE, GAP: begin
                    if (pick_vld) begin
                        gnt       <= 8'd1 << pick_id;
                        gnt_id    <= pick_id;
                        gnt_valid <= 1'b1;
                        state     <= BUSY;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt  <= 8'd1;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    // A voluntary drop wins over the limit, so timeout only fires while req is still held.
                    if (!hold_req || force_rel) begin
                        gnt       <= 8'd0;
                        gnt_id    <= 3'd0;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_id + 3'd1;
                        state     <= GAP;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt  <= 8'd0;
                        timeout_q <= hold_req;
`endif
                    end
`ifdef ARB_TIMEOUT_EN
                    else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
`endif
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= 8'd0;
                    gnt_id    <= 3'd0;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb_rr8_enc.sv
// Directed bench for arb_rr8_enc; HOLD_MAX=4 so the timeout scenario is short when ARB_TIMEOUT_EN is set.
module tb_arb_rr8_enc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'd0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int failures = 0;
    int mon_checks = 0;
    int mon_fail = 0;

    arb_rr8_enc #(.HOLD_MAX(4)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .gnt(gnt),
        .gnt_id(gnt_id),
        .gnt_valid(gnt_valid),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Structural invariants of the grant outputs, every cycle.
    always @(negedge clk) begin
        automatic int         pc  = 0;
        automatic logic [2:0] enc = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (gnt[i]) begin
                pc++;
                enc = i[2:0];
            end
        end
        mon_checks++;
        if (pc > 1) begin
            mon_fail++;
            $display("FAIL onehot: gnt=%h popcount=%0d required<=1", gnt, pc);
        end
        mon_checks++;
        if (gnt_id !== enc) begin
            mon_fail++;
            $display("FAIL encode: gnt_id=%0d required=%0d (gnt=%h)", gnt_id, enc, gnt);
        end
        mon_checks++;
        if (gnt_valid !== (|gnt)) begin
            mon_fail++;
            $display("FAIL valid: gnt_valid=%b required=%b (gnt=%h)", gnt_valid, |gnt, gnt);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 8'd0;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic expect_gnt(input string name, input logic [7:0] eg, input logic [2:0] eid, input logic ev);
        checks++;
        if (gnt !== eg || gnt_id !== eid || gnt_valid !== ev) begin
            failures++;
            $display("FAIL %s: gnt=%h id=%0d vld=%b required gnt=%h id=%0d vld=%b",
                     name, gnt, gnt_id, gnt_valid, eg, eid, ev);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'h04;
        cyc();
        expect_gnt("reset_hold", 8'h00, 3'd0, 1'b0);
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_timeout: timeout=%b required=0", timeout);
        end
        rst = 1'b0;
        cyc();
        expect_gnt("first_arb", 8'h04, 3'd2, 1'b1);
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h04;
        for (int k = 0; k < 3; k++) begin
            cyc();
            expect_gnt("single_hold", 8'h04, 3'd2, 1'b1);
        end
        req = 8'h00;
        cyc();
        expect_gnt("single_gap", 8'h00, 3'd0, 1'b0);
        cyc();
        expect_gnt("single_idle", 8'h00, 3'd0, 1'b0);
        req = 8'h05;
        cyc();
        expect_gnt("ptr_wrap", 8'h01, 3'd0, 1'b1);
        req = 8'h00;
        cyc();
        cyc();
    endtask

    task automatic test_rotate();
        logic [2:0] eid;
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            eid = 3'(k % 8);
            cyc();
            expect_gnt("rotate_grant", 8'd1 << eid, eid, 1'b1);
            req = 8'hFF & ~(8'd1 << eid);
            cyc();
            expect_gnt("rotate_gap", 8'h00, 3'd0, 1'b0);
            req = 8'hFF;
        end
        req = 8'h00;
        cyc();
        cyc();
    endtask

    task automatic test_same();
        do_reset();
        req = 8'h80;
        cyc();
        expect_gnt("same_first", 8'h80, 3'd7, 1'b1);
        req = 8'h00;
        cyc();
        expect_gnt("same_gap", 8'h00, 3'd0, 1'b0);
        req = 8'h80;
        cyc();
        expect_gnt("same_regrant", 8'h80, 3'd7, 1'b1);
        req = 8'h00;
        cyc();
        cyc();
    endtask

    task automatic test_busy_hold();
        do_reset();
        req = 8'h02;
        cyc();
        expect_gnt("busy_first", 8'h02, 3'd1, 1'b1);
        req = 8'h03;
        cyc();
        expect_gnt("busy_ignore_new", 8'h02, 3'd1, 1'b1);
        req = 8'hFF;
        cyc();
        expect_gnt("busy_ignore_all", 8'h02, 3'd1, 1'b1);
        req = 8'h21;
        cyc();
        expect_gnt("busy_release", 8'h00, 3'd0, 1'b0);
        cyc();
        expect_gnt("busy_rr_next", 8'h20, 3'd5, 1'b1);
        req = 8'h00;
        cyc();
        cyc();
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 8'h10;
        cyc();
        expect_gnt("midrst_grant", 8'h10, 3'd4, 1'b1);
        rst = 1'b1;
        #1;
        expect_gnt("midrst_async", 8'h00, 3'd0, 1'b0);
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL midrst_timeout: timeout=%b required=0", timeout);
        end
        cyc();
        rst = 1'b0;
        req = 8'h11;
        cyc();
        expect_gnt("midrst_ptr0", 8'h01, 3'd0, 1'b1);
        req = 8'h00;
        cyc();
        cyc();
    endtask

    task automatic expect_to(input string name, input logic et);
        checks++;
        if (timeout !== et) begin
            failures++;
            $display("FAIL %s: timeout=%b required=%b", name, timeout, et);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req = 8'h03;
        for (int k = 0; k < 4; k++) begin
            cyc();
            expect_gnt("to_hold0", 8'h01, 3'd0, 1'b1);
            expect_to("to_quiet0", 1'b0);
        end
        cyc();
        expect_gnt("to_gap0", 8'h00, 3'd0, 1'b0);
        expect_to("to_pulse0", 1'b1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            expect_gnt("to_hold1", 8'h02, 3'd1, 1'b1);
            expect_to("to_quiet1", 1'b0);
        end
        cyc();
        expect_gnt("to_gap1", 8'h00, 3'd0, 1'b0);
        expect_to("to_pulse1", 1'b1);
        cyc();
        expect_gnt("to_back0", 8'h01, 3'd0, 1'b1);
        expect_to("to_quiet2", 1'b0);
        // Voluntary drop exactly at the limit edge: no timeout pulse.
        do_reset();
        req = 8'h01;
        for (int k = 0; k < 4; k++) begin
            cyc();
            expect_gnt("to_norm_hold", 8'h01, 3'd0, 1'b1);
        end
        req = 8'h00;
        cyc();
        expect_gnt("to_norm_gap", 8'h00, 3'd0, 1'b0);
        expect_to("to_norm_nopulse", 1'b0);
        cyc();
    endtask
`else
    task automatic test_timeout();
        do_reset();
        req = 8'h03;
        for (int k = 0; k < 20; k++) begin
            cyc();
            expect_gnt("unbounded_hold", 8'h01, 3'd0, 1'b1);
            expect_to("timeout_tied0", 1'b0);
        end
        req = 8'h00;
        cyc();
        expect_gnt("unbounded_release", 8'h00, 3'd0, 1'b0);
        expect_to("timeout_tied0_rel", 1'b0);
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_rotate();
        test_same();
        test_busy_hold();
        test_mid_reset();
        test_timeout();
        @(negedge clk);
        checks   += mon_checks;
        failures += mon_fail;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arb_rr8_enc.md
ARB_RR8_ENC -- requirements
Module: arb_rr8_enc

Interface
REQ-001 SHALL have parameter: HOLD_MAX, 15, max BUSY cycles per grant under timeout (range 2..255).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: req  input  8  request vector, bit k = requester k, level-sensitive.
REQ-005 SHALL have port: gnt  output  8  registered one-hot grant, all-zero when no grant.
REQ-006 SHALL have port: gnt_id  output  3  registered binary index of the set gnt bit, 0 when gnt_valid=0.
REQ-007 SHALL have port: gnt_valid  output  1  registered, 1 iff gnt nonzero.
REQ-008 SHALL have port: timeout  output  1  registered one-cycle pulse on forced release (tied 0 without ARB_TIMEOUT_EN).

Function
REQ-009 SHALL implement FSM states IDLE, BUSY, GAP; no other reachable states.
REQ-010 SHALL keep 3-bit priority pointer ptr; search order ptr, ptr+1, ..., wrapping 7->0.
REQ-011 IDLE or GAP with req!=0 at edge N SHALL set gnt/gnt_id/gnt_valid to first requester in search order at edge N (visible after edge N), enter BUSY.
REQ-012 IDLE with req==0 SHALL stay IDLE, outputs zero; GAP with req==0 SHALL go IDLE.
REQ-013 BUSY SHALL hold gnt, gnt_id unchanged while req[gnt_id]=1, regardless of other req bits.
REQ-014 BUSY with req[gnt_id]=0 at an edge SHALL clear gnt/gnt_valid/gnt_id at that edge, set ptr=gnt_id+1 mod 8, enter GAP.
REQ-015 GAP SHALL last exactly one cycle with gnt all-zero, guaranteeing >=1 idle cycle between any two grants.
REQ-016 Requests rising during BUSY SHALL be served no earlier than the cycle after GAP, in round-robin order from updated ptr.
REQ-017 Same requester SHALL be re-granted after GAP only if no other req bit set (starvation-free, max wait 7 grants).
REQ-018 gnt SHALL never have more than one bit set; gnt_id SHALL always equal encode(gnt).
REQ-019 Grant SHALL not depend on req bits other than first-in-order at grant edge; glitches between edges SHALL be ignored.

Reset
REQ-020 rst=1 SHALL asynchronously force state=IDLE, ptr=0, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, hold counter=0.
REQ-021 rst asserted mid-BUSY SHALL drop grant immediately without GAP or timeout pulse; first grant after release uses ptr=0.
REQ-022 First arbitration SHALL occur at first rising edge with rst=0.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN defined: hold counter SHALL count BUSY cycles from 1 at grant edge; at edge where count==HOLD_MAX and req[gnt_id]=1, SHALL clear grant, pulse timeout for one cycle, ptr=gnt_id+1, enter GAP.
REQ-024 Macro ARB_TIMEOUT_EN defined: normal release (REQ-014) on same edge as count==HOLD_MAX SHALL take priority, timeout stays 0.
REQ-025 Macro ARB_TIMEOUT_EN undefined: no hold counter, grant unbounded, timeout constant 0, HOLD_MAX ignored.

Verification
REQ-026 rst pulse mid-grant req=8'h10 -> gnt=0, gnt_valid=0 asynchronously before next edge; after release, req=8'h11 -> gnt=8'h01, gnt_id=0.
REQ-027 req=8'hFF held, each holder drops req one cycle then reasserts -> grant sequence gnt_id 0,1,...,7,0 with one GAP cycle between each.
REQ-028 From ptr=0: req=8'h04 for 3 cycles then 0 -> gnt=8'h04, gnt_id=2 for 3 cycles, one GAP, IDLE, ptr=3; then req=8'h05 -> gnt_id=0 (wraps past 3..7).
REQ-029 req=8'h80 alone, release, req=8'h80 again -> re-granted gnt_id=7 after one GAP cycle (no other requester).
REQ-030 ARB_TIMEOUT_EN, HOLD_MAX=4, req=8'h03 held -> gnt_id=0 for 4 cycles, timeout=1 one cycle, GAP, gnt_id=1 for 4 cycles, timeout, GAP, gnt_id=0.
REQ-031 Every cycle, all tests: check popcount(gnt)<=1, gnt_id==encode(gnt), gnt_valid==|gnt.
